// File: rtl/mpmc11_pkg.sv
// Shared types for the mpmc11 memory controller slice: controller state, arbiter
// state and a small one-hot to index helper.
package mpmc11_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACTIVATE  = 3'd1,
    READ      = 3'd2,
    WRITE     = 3'd3,
    PRECHARGE = 3'd4,
    REFRESH   = 3'd5
  } mpmc11_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OFFER = 2'd1,
    ARB_BUSY  = 2'd2
  } mpmc11_arb_state_t;

  localparam int MPMC11_MAX_CH = 16;

  // OR-reduce the positions of set bits; exact for any one-hot or all-zero input.
  function automatic logic [3:0] mpmc11_oh2idx(input logic [MPMC11_MAX_CH-1:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < MPMC11_MAX_CH; i++) begin
      idx = idx | ({4{oh[i]}} & 4'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/mpmc11_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last,
// wrapping from NCH-1 back to 0.
module mpmc11_rr_pick
  import mpmc11_pkg::*;
#(
  parameter int  NCH = 8,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_last,
  output logic [NCH-1:0] o_win_oh,
  output logic           o_found
);

  // Scan NCH positions starting one past the last winner
  always_comb begin
    int            idx;
    logic [CW-1:0] sel;
    logic          hit;
    o_win_oh = '0;
    o_found  = 1'b0;
    idx      = 0;
    sel      = '0;
    hit      = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx           = int'(i_last) + k;
      idx           = (idx >= NCH) ? (idx - NCH) : idx;
      sel           = CW'(idx);
      hit           = i_req[sel] & ~o_found;
      o_win_oh[sel] = hit;
      o_found       = o_found | hit;
    end
  end

endmodule

// File: rtl/mpmc11_port_arbiter.sv
// Channel arbiter in front of the mpmc11 controller: starved channels first, then
// round-robin, with an offer/accept/done handshake against the controller state.
module mpmc11_port_arbiter
  import mpmc11_pkg::*;
#(
  parameter int  NCH          = 8,
  parameter int  STARVE_LIMIT = 15,
  localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int WW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  mpmc11_state_t  state,
  input  logic [NCH-1:0] req,
  input  logic           done,
  output logic           grant_valid,
  output logic [NCH-1:0] grant_oh,
  output logic [CW-1:0]  grant_ch,
  output logic [NCH-1:0] starved
);

  localparam logic [WW-1:0] LIM = WW'(STARVE_LIMIT);

  mpmc11_arb_state_t r_state;
  mpmc11_arb_state_t w_next_state;
  logic              r_grant_valid;
  logic [NCH-1:0]    r_grant_oh;
  logic [CW-1:0]     r_grant_ch;
  logic [CW-1:0]     r_last;
  logic [WW-1:0]     r_wait     [NCH];
  logic [WW-1:0]     w_wait_nxt [NCH];
  logic [NCH-1:0]    r_starved;
  logic [NCH-1:0]    w_rr_oh;
  logic [NCH-1:0]    w_stv_oh;
  logic [NCH-1:0]    w_win_oh;
  logic              w_rr_found;
  logic              w_stv_found;
  logic [CW-1:0]     w_win_ch;
  logic              w_decide;
  logic              w_drop;
  logic              w_release;

  mpmc11_rr_pick #(.NCH(NCH)) u_rr_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_win_oh (w_rr_oh),
    .o_found  (w_rr_found)
  );

  // Lowest-index requester whose wait counter has saturated
  always_comb begin
    w_stv_oh    = '0;
    w_stv_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_stv_oh[i] = req[i] & r_starved[i] & ~w_stv_found;
      w_stv_found = w_stv_found | w_stv_oh[i];
    end
  end

  assign w_win_oh = w_stv_found ? w_stv_oh : w_rr_oh;
  assign w_win_ch = CW'(mpmc11_oh2idx(MPMC11_MAX_CH'(w_win_oh)));

  // Next arbiter state and the decide/drop/release events
  always_comb begin
    w_next_state = r_state;
    w_decide     = 1'b0;
    w_drop       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if ((state == IDLE) && (w_stv_found || w_rr_found)) begin
          w_next_state = ARB_OFFER;
          w_decide     = 1'b1;
        end else begin
          w_next_state = ARB_IDLE;
        end
      end
      ARB_OFFER: begin
        // Acceptance by the controller outranks a late request withdrawal.
        if (state != IDLE) begin
          w_next_state = ARB_BUSY;
        end else if ((req & r_grant_oh) == '0) begin
          w_next_state = ARB_IDLE;
          w_drop       = 1'b1;
        end else begin
          w_next_state = ARB_OFFER;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          w_next_state = ARB_IDLE;
          w_release    = 1'b1;
        end else begin
          w_next_state = ARB_BUSY;
        end
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state, registered grant and round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ARB_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_oh    <= '0;
      r_grant_ch    <= '0;
      r_last        <= CW'(NCH - 1);
    end else begin
      r_state       <= w_next_state;
      r_grant_valid <= (w_next_state == ARB_OFFER);
      if (w_decide) begin
        r_grant_oh <= w_win_oh;
        r_grant_ch <= w_win_ch;
      end else if (w_drop || w_release) begin
        r_grant_oh <= '0;
        r_grant_ch <= '0;
      end else begin
        r_grant_oh <= r_grant_oh;
        r_grant_ch <= r_grant_ch;
      end
      if (w_release) begin
        r_last <= r_grant_ch;
      end else begin
        r_last <= r_last;
      end
    end
  end

  // Saturating wait counters: idle channels clear, losers of a decision count up
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_wait_nxt[i] = r_wait[i];
      if (!req[i]) begin
        w_wait_nxt[i] = '0;
      end else if (w_decide && w_win_oh[i]) begin
        w_wait_nxt[i] = '0;
      end else if (w_decide && (r_wait[i] != LIM)) begin
        w_wait_nxt[i] = r_wait[i] + WW'(1);
      end else begin
        w_wait_nxt[i] = r_wait[i];
      end
    end
  end

  // Wait counter and starved flag registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        r_wait[i] <= '0;
      end
      r_starved <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_wait[i]    <= w_wait_nxt[i];
        r_starved[i] <= (w_wait_nxt[i] == LIM);
      end
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_oh    = r_grant_oh;
  assign grant_ch    = r_grant_ch;
  assign starved     = r_starved;

endmodule
